// File: rtl/bus_slave_responder.sv
// bus_slave_responder
//   Slave-side endpoint of the system bus. Accepts one read or write burst
//   request, serves it from a local register-file memory, streams read beats
//   back on new_data/new_rx and pulses rx_done / tx_done when the burst ends.
//   Requests whose address lies outside the local memory complete at once
//   with addr_err and touch no memory.
//
//   Optional feature macro: SLAVE_WAIT_EN
//     When defined, WAIT_CYCLES idle cycles precede every data beat (WAIT
//     state). When undefined, the WAIT state and its counter are not built.
module bus_slave_responder #(
    parameter int ADDR_LEN     = 12,
    parameter int DATA_LEN     = 8,
    parameter int BURST_LEN    = 12,
    parameter int MEM_ADDR_LEN = 8
`ifdef SLAVE_WAIT_EN
    ,
    parameter int WAIT_CYCLES  = 2
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    input  logic                 req_read,
    input  logic [ADDR_LEN-1:0]  address,
    input  logic [BURST_LEN-1:0] burst_num,
    input  logic [DATA_LEN-1:0]  wdata,
    input  logic                 wdata_valid,
    output logic                 wready,
    output logic [DATA_LEN-1:0]  new_data,
    output logic                 new_rx,
    output logic                 rx_done,
    output logic                 tx_done,
    output logic                 addr_err,
    output logic                 busy
);

    localparam int MEM_DEPTH = 2 ** MEM_ADDR_LEN;

`ifdef SLAVE_WAIT_EN
    localparam int WAIT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    typedef enum logic [2:0] {IDLE, WAIT, READ, WRITE, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
`endif

    state_t                 state_q, state_d;
    logic [MEM_ADDR_LEN-1:0] ptr_q, ptr_d;
    logic [BURST_LEN-1:0]   beats_q, beats_d;
    logic                   rd_q, rd_d;
    logic                   err_q, err_d;
    logic                   mem_we;
    logic                   busy_d, wready_d, new_rx_d;
    logic                   rx_done_d, tx_done_d, addr_err_d;
`ifdef SLAVE_WAIT_EN
    logic [WAIT_W-1:0]      wait_q, wait_d;
`endif

    logic [DATA_LEN-1:0]    mem [MEM_DEPTH];

    // State entered before each data beat: the wait phase if built, else the beat itself.
    function automatic state_t beat_state(input logic is_read);
`ifdef SLAVE_WAIT_EN
        if (WAIT_CYCLES > 0) return WAIT;
`endif
        return is_read ? READ : WRITE;
    endfunction

    // Next-state, datapath updates and next values of the registered outputs.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d = state_q;
        ptr_d   = ptr_q;
        beats_d = beats_q;
        rd_d    = rd_q;
        err_d   = err_q;
        mem_we  = 1'b0;
`ifdef SLAVE_WAIT_EN
        wait_d  = wait_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    rd_d    = req_read;
                    ptr_d   = address[MEM_ADDR_LEN-1:0];
                    beats_d = (burst_num == '0) ? BURST_LEN'(1) : burst_num;
                    err_d   = (address[ADDR_LEN-1:MEM_ADDR_LEN] != '0);
                    state_d = err_d ? DONE : beat_state(req_read);
                end
            end
`ifdef SLAVE_WAIT_EN
            WAIT: begin
                if (wait_q == WAIT_W'(WAIT_CYCLES - 1)) begin
                    wait_d  = '0;
                    state_d = rd_q ? READ : WRITE;
                end else begin
                    wait_d  = wait_q + 1'b1;
                end
            end
`endif
            READ: begin
                ptr_d   = ptr_q + 1'b1;
                beats_d = beats_q - 1'b1;
                state_d = (beats_q == BURST_LEN'(1)) ? DONE : beat_state(1'b1);
            end
            WRITE: begin
                if (wdata_valid) begin
                    mem_we  = 1'b1;
                    ptr_d   = ptr_q + 1'b1;
                    beats_d = beats_q - 1'b1;
                    state_d = (beats_q == BURST_LEN'(1)) ? DONE : beat_state(1'b0);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d     = (state_d != IDLE) || (state_q == DONE);
        wready_d   = (state_d == WRITE);
        new_rx_d   = (state_q == READ);
        rx_done_d  = (state_q == DONE) && rd_q;
        tx_done_d  = (state_q == DONE) && !rd_q;
        addr_err_d = (state_q == DONE) && err_q;
    end

    // State and request-context registers.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            beats_q <= '0;
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
`ifdef SLAVE_WAIT_EN
            wait_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            beats_q <= beats_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
`ifdef SLAVE_WAIT_EN
            wait_q  <= wait_d;
`endif
        end
    end

    // Registered outputs; new_data only changes on a read beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy     <= 1'b0;
            wready   <= 1'b0;
            new_rx   <= 1'b0;
            rx_done  <= 1'b0;
            tx_done  <= 1'b0;
            addr_err <= 1'b0;
            new_data <= '0;
        end else begin
            busy     <= busy_d;
            wready   <= wready_d;
            new_rx   <= new_rx_d;
            rx_done  <= rx_done_d;
            tx_done  <= tx_done_d;
            addr_err <= addr_err_d;
            if (state_q == READ) new_data <= mem[ptr_q];
        end
    end

    // Local storage, written one beat per accepted write cycle.
    always_ff @(posedge clk) begin
        // NOTE: the memory array has no reset; written words must survive a bus reset.
        if (mem_we) mem[ptr_q] <= wdata;
    end

endmodule

// File: tb/tb_bus_slave_responder.sv
// tb_bus_slave_responder
//   Transaction-level model: each request is turned into a per-cycle timeline
//   of expected outputs (from beat counts and wait spacing) plus a word-array
//   memory image; one negedge process compares the DUT against that timeline.
//   Directed scenarios add literal expectations; a random phase follows.
module tb_bus_slave_responder;

    localparam int AL    = 12;
    localparam int DL    = 8;
    localparam int BL    = 12;
    localparam int ML    = 8;
    localparam int DEPTH = 256;
    localparam int MAXC  = 20000;
`ifdef SLAVE_WAIT_EN
    localparam int W = 2;
`else
    localparam int W = 0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_read = 1'b0;
    logic [AL-1:0] address = '0;
    logic [BL-1:0] burst_num = '0;
    logic [DL-1:0] wdata = '0;
    logic          wdata_valid = 1'b0;
    logic          wready, new_rx, rx_done, tx_done, addr_err, busy;
    logic [DL-1:0] new_data;

    bus_slave_responder #(
        .ADDR_LEN(AL), .DATA_LEN(DL), .BURST_LEN(BL), .MEM_ADDR_LEN(ML)
`ifdef SLAVE_WAIT_EN
        , .WAIT_CYCLES(W)
`endif
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_read(req_read),
        .address(address), .burst_num(burst_num), .wdata(wdata),
        .wdata_valid(wdata_valid), .wready(wready), .new_data(new_data),
        .new_rx(new_rx), .rx_done(rx_done), .tx_done(tx_done),
        .addr_err(addr_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit            exp_busy[MAXC], exp_rx[MAXC], exp_rxd[MAXC], exp_txd[MAXC];
    bit            exp_err[MAXC], exp_wr[MAXC], exp_rst[MAXC];
    logic [DL-1:0] exp_data[MAXC];
    bit            drv_wv[MAXC];
    logic [DL-1:0] drv_wd[MAXC];
    logic [DL-1:0] mem_m[DEPTH];
    logic [DL-1:0] wq_data[$];
    int            wq_gap[$];
    logic [DL-1:0] rd_log[$];
    logic [DL-1:0] last_data = '0;
    int            n_vec = 0;
    int            n_err = 0;
    bit            noise_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle comparison against the expected timeline.
    always @(negedge clk) begin
        if (cyc < MAXC) begin
            if (exp_rst[cyc]) last_data = '0;
            if (exp_rx[cyc])  last_data = exp_data[cyc];
            check("busy",     busy,     exp_busy[cyc]);
            check("wready",   wready,   exp_wr[cyc]);
            check("new_rx",   new_rx,   exp_rx[cyc]);
            check("rx_done",  rx_done,  exp_rxd[cyc]);
            check("tx_done",  tx_done,  exp_txd[cyc]);
            check("addr_err", addr_err, exp_err[cyc]);
            check("new_data", new_data, last_data);
            if (new_rx) rd_log.push_back(new_data);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Schedule the expected timeline of one request and present it at edge T.
    task automatic start_req(input bit rd, input logic [AL-1:0] addr, input logic [BL-1:0] burst,
                             output int T, output int D);
        int n, c, s, e, a;
        T = cyc + 1;
        a = int'(addr);
        n = (burst == 0) ? 1 : int'(burst);
        if (addr[AL-1:ML] != 0) begin
            D = T + 1;
            exp_err[D] = 1'b1;
            if (rd) exp_rxd[D] = 1'b1; else exp_txd[D] = 1'b1;
        end else if (rd) begin
            c = T;
            for (int i = 0; i < n; i++) begin
                c += W + 1;
                exp_rx[c]   = 1'b1;
                exp_data[c] = mem_m[(a + i) % DEPTH];
            end
            D = c + 1;
            exp_rxd[D] = 1'b1;
        end else begin
            c = T;
            for (int i = 0; i < n; i++) begin
                s = c + W;
                for (int k = c + 1; k <= s; k++) drv_wv[k] = 1'($urandom);
                e = s + 1 + wq_gap[i];
                for (int k = s; k < e; k++) exp_wr[k] = 1'b1;
                drv_wv[e] = 1'b1;
                drv_wd[e] = wq_data[i];
                mem_m[(a + i) % DEPTH] = wq_data[i];
                c = e;
            end
            D = c + 1;
            exp_txd[D] = 1'b1;
        end
        drv_wv[D] = 1'($urandom);
        for (int k = T; k <= D; k++) exp_busy[k] = 1'b1;
        req_valid   = 1'b1;
        req_read    = rd;
        address     = addr;
        burst_num   = burst;
        wdata_valid = 1'($urandom);
        wdata       = DL'($urandom);
        step();
    endtask

    // Drive the scheduled write beats (and optional ignored request noise) up to edge E.
    task automatic run_until(input int E);
        int k;
        while (cyc < E) begin
            k = cyc + 1;
            wdata_valid = drv_wv[k];
            wdata       = drv_wv[k] ? drv_wd[k] : DL'($urandom);
            if (noise_en) begin
                req_valid = 1'($urandom);
                req_read  = 1'($urandom);
                address   = AL'($urandom);
                burst_num = BL'($urandom);
            end else begin
                req_valid = 1'b0;
            end
            step();
        end
        req_valid   = 1'b0;
        wdata_valid = 1'b0;
    endtask

    task automatic txn(input bit rd, input logic [AL-1:0] addr, input logic [BL-1:0] burst);
        int t, d;
        start_req(rd, addr, burst, t, d);
        run_until(d);
    endtask

    initial begin
        int t, d, sz, n;
        logic [AL-1:0] ra;
        logic [BL-1:0] rb;
        bit rr;

        #1;
        check("rst_busy", busy, 0);
        check("rst_new_rx", new_rx, 0);
        check("rst_new_data", new_data, 0);
        check("rst_done", {rx_done, tx_done, addr_err, wready}, 0);
        repeat (3) step();
        reset = 1'b1;
        step();

        // Write burst of 3 at address 5 on consecutive cycles.
        wq_data = '{8'hAA, 8'hBB, 8'hCC};
        wq_gap  = '{0, 0, 0};
        txn(1'b0, 12'd5, 12'd3);
        check("t1_tx_done", tx_done, 1);
        check("t1_addr_err", addr_err, 0);

        // Read it back.
        sz = rd_log.size();
        txn(1'b1, 12'd5, 12'd3);
        check("t2_beats", rd_log.size() - sz, 3);
        check("t2_beat0", rd_log[sz], 8'hAA);
        check("t2_beat1", rd_log[sz+1], 8'hBB);
        check("t2_beat2", rd_log[sz+2], 8'hCC);
        check("t2_rx_done", rx_done, 1);
        step();
        check("t2_busy_low", busy, 0);

        // Pointer wrap and burst_num = 0.
        wq_data = '{8'h11, 8'h22};
        wq_gap  = '{0, 1};
        txn(1'b0, 12'd255, 12'd2);
        txn(1'b1, 12'd0, 12'd1);
        check("t3_wrap_data", new_data, 8'h22);
        sz = rd_log.size();
        txn(1'b1, 12'd5, 12'd0);
        check("t3_zero_burst_beats", rd_log.size() - sz, 1);
        check("t3_zero_burst_data", new_data, 8'hAA);

        // Out-of-range read and write.
        sz = rd_log.size();
        txn(1'b1, 12'h100, 12'd3);
        check("t4_rd_err", {rx_done, addr_err}, 2'b11);
        check("t4_no_beats", rd_log.size() - sz, 0);
        wq_data = '{8'h99, 8'h98};
        wq_gap  = '{0, 0};
        txn(1'b0, 12'h800, 12'd2);
        check("t4_wr_err", {tx_done, addr_err}, 2'b11);
        txn(1'b1, 12'd0, 12'd1);
        check("t4_mem_intact", new_data, 8'h22);

        // Fill the whole memory with one 256-beat write.
        wq_data.delete();
        wq_gap.delete();
        for (int i = 0; i < DEPTH; i++) begin
            wq_data.push_back(DL'($urandom));
            wq_gap.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : 0);
        end
        txn(1'b0, 12'd0, 12'd256);

        // Reset during beat 2 of a 4-beat read.
        start_req(1'b1, 12'd10, 12'd4, t, d);
        run_until(t + 2);
        #1;
        reset = 1'b0;
        #1;
        check("t5_busy", busy, 0);
        check("t5_new_rx", new_rx, 0);
        check("t5_new_data", new_data, 0);
        check("t5_done", {rx_done, tx_done, addr_err}, 0);
        for (int k = t + 3; k <= d; k++) begin
            exp_busy[k] = 1'b0; exp_rx[k] = 1'b0; exp_rxd[k] = 1'b0;
            exp_txd[k]  = 1'b0; exp_err[k] = 1'b0; exp_wr[k] = 1'b0;
            drv_wv[k]   = 1'b0;
        end
        exp_rst[t + 3] = 1'b1;
        step();
        reset = 1'b1;
        txn(1'b1, 12'd10, 12'd4);

        // Random traffic with ignored request noise while busy.
        noise_en = 1'b1;
        for (int j = 0; j < 150; j++) begin
            if (cyc > MAXC - 2000) break;
            rr = 1'($urandom);
            ra = ($urandom_range(0, 4) == 0) ? AL'($urandom) : AL'($urandom_range(0, DEPTH - 1));
            case ($urandom_range(0, 19))
                0, 1:    rb = '0;
                2:       rb = BL'($urandom_range(20, 80));
                default: rb = BL'($urandom_range(1, 12));
            endcase
            n = (rb == 0) ? 1 : int'(rb);
            wq_data.delete();
            wq_gap.delete();
            for (int i = 0; i < n; i++) begin
                wq_data.push_back(DL'($urandom));
                wq_gap.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : 0);
            end
            txn(rr, ra, rb);
            repeat ($urandom_range(0, 2)) step();
        end
        noise_en = 1'b0;
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
